// File: rtl/expr_pipe_eval_if.sv
// rtl/expr_pipe_eval_if.sv - operation, result and signature signals of expr_pipe_eval
interface expr_pipe_eval_if #(
    parameter int W  = 4,
    parameter int RW = W + 1,
    parameter int CW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic          in_sa;
    logic          in_sb;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [W-1:0]  in_c;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_y;
    logic          out_err;
    logic          sig_clr;
    logic [RW-1:0] sig;
    logic [CW-1:0] count;

    modport master (
        output in_valid, in_op, in_sa, in_sb, in_a, in_b, in_c, out_ready, sig_clr,
        input  in_ready, out_valid, out_y, out_err, sig, count
    );

    modport slave (
        input  in_valid, in_op, in_sa, in_sb, in_a, in_b, in_c, out_ready, sig_clr,
        output in_ready, out_valid, out_y, out_err, sig, count
    );
endinterface

// File: rtl/expr_pipe_eval.sv
// rtl/expr_pipe_eval.sv - two-stage mixed-signedness expression evaluator with running signature
module expr_pipe_eval #(
    parameter int W  = 4,
    parameter int RW = W + 1,
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            rst,
    expr_pipe_eval_if.slave bus
);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SHL  = 4'd2;
    localparam logic [3:0] OP_SHR  = 4'd3;
    localparam logic [3:0] OP_LT   = 4'd4;
    localparam logic [3:0] OP_EQ   = 4'd5;
    localparam logic [3:0] OP_SEL  = 4'd6;
    localparam logic [3:0] OP_RXOR = 4'd7;

    logic          ctx_signed;
    logic [RW-1:0] ext_a;
    logic [RW-1:0] ext_b;

    logic          s2_adv;
    logic          in_ready;
    logic          in_fire;
    logic          out_fire;

    logic          s1_valid_q,  s1_valid_d;
    logic [RW-1:0] s1_ea_q,     s1_ea_d;
    logic [RW-1:0] s1_eb_q,     s1_eb_d;
    logic [3:0]    s1_op_q,     s1_op_d;
    logic          s1_signed_q, s1_signed_d;
    logic [W-1:0]  s1_c_q,      s1_c_d;

    logic          s2_valid_q,  s2_valid_d;
    logic [RW-1:0] y_q,         y_d;
    logic          err_q,       err_d;

    logic [RW-1:0] sig_q,       sig_d;
    logic [CW-1:0] count_q,     count_d;

    logic [W-1:0]  raw_a;
    logic [W-1:0]  raw_b;
    logic [RW-1:0] alu_y;
    logic          alu_err;

    // Mixed signedness demotes the whole expression to unsigned, as in Verilog.
    always_comb begin
        ctx_signed = bus.in_sa & bus.in_sb;
        if (ctx_signed) begin
            ext_a = RW'($signed(bus.in_a));
            ext_b = RW'($signed(bus.in_b));
        end else begin
            ext_a = RW'(bus.in_a);
            ext_b = RW'(bus.in_b);
        end
    end

    always_comb begin
        s2_adv   = !s2_valid_q | bus.out_ready;
        in_ready = !s1_valid_q | s2_adv;
        in_fire  = bus.in_valid & in_ready;
        out_fire = s2_valid_q & bus.out_ready;
    end

    // Shift cases use separate statements so the arithmetic shift never lands in an unsigned ternary.
    always_comb begin
        raw_a   = s1_ea_q[W-1:0];
        raw_b   = s1_eb_q[W-1:0];
        alu_y   = '0;
        alu_err = 1'b0;
        case (s1_op_q)
            OP_ADD: alu_y = s1_ea_q + s1_eb_q;
            OP_SUB: alu_y = s1_ea_q - s1_eb_q;
            OP_SHL: alu_y = s1_ea_q << raw_b;
            OP_SHR: begin
                if (s1_signed_q) begin
                    alu_y = $signed(s1_ea_q) >>> raw_b;
                end else begin
                    alu_y = s1_ea_q >> raw_b;
                end
            end
            OP_LT: begin
                if (s1_signed_q) begin
                    alu_y = RW'($signed(s1_ea_q) < $signed(s1_eb_q));
                end else begin
                    alu_y = RW'(s1_ea_q < s1_eb_q);
                end
            end
            OP_EQ: alu_y = RW'(raw_a == raw_b);
            OP_SEL: begin
                if (s1_c_q != '0) begin
                    alu_y = s1_ea_q;
                end else begin
                    alu_y = s1_eb_q;
                end
            end
            OP_RXOR: alu_y = RW'(^raw_a);
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_ea_d     = s1_ea_q;
        s1_eb_d     = s1_eb_q;
        s1_op_d     = s1_op_q;
        s1_signed_d = s1_signed_q;
        s1_c_d      = s1_c_q;
        if (in_ready) begin
            s1_valid_d = bus.in_valid;
        end
        if (in_fire) begin
            s1_ea_d     = ext_a;
            s1_eb_d     = ext_b;
            s1_op_d     = bus.in_op;
            s1_signed_d = ctx_signed;
            s1_c_d      = bus.in_c;
        end

        s2_valid_d = s2_valid_q;
        y_d        = y_q;
        err_d      = err_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                y_d   = alu_y;
                err_d = alu_err;
            end
        end

        sig_d   = sig_q;
        count_d = count_q;
        if (bus.sig_clr) begin
            sig_d   = out_fire ? y_q : '0;
            count_d = out_fire ? CW'(1) : '0;
        end else if (out_fire) begin
            sig_d   = {sig_q[RW-2:0], sig_q[RW-1]} ^ y_q;
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_ea_q     <= '0;
            s1_eb_q     <= '0;
            s1_op_q     <= '0;
            s1_signed_q <= 1'b0;
            s1_c_q      <= '0;
            s2_valid_q  <= 1'b0;
            y_q         <= '0;
            err_q       <= 1'b0;
            sig_q       <= '0;
            count_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_ea_q     <= s1_ea_d;
            s1_eb_q     <= s1_eb_d;
            s1_op_q     <= s1_op_d;
            s1_signed_q <= s1_signed_d;
            s1_c_q      <= s1_c_d;
            s2_valid_q  <= s2_valid_d;
            y_q         <= y_d;
            err_q       <= err_d;
            sig_q       <= sig_d;
            count_q     <= count_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_y     = y_q;
    assign bus.out_err   = err_q;
    assign bus.sig       = sig_q;
    assign bus.count     = count_q;

endmodule

// File: tb/tb_expr_pipe_eval.sv
// tb/tb_expr_pipe_eval.sv - scoreboard bench for expr_pipe_eval
module tb_expr_pipe_eval;

    localparam int W  = 4;
    localparam int RW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    expr_pipe_eval_if #(.W(W), .RW(RW), .CW(16)) bus ();
    expr_pipe_eval_if #(.W(W), .RW(RW), .CW(3))  bus_w ();

    expr_pipe_eval #(.W(W), .RW(RW), .CW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    expr_pipe_eval #(.W(W), .RW(RW), .CW(3)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w.slave)
    );

    int checks = 0;
    int errors = 0;
    int occ    = 0;
    logic [RW:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic send(input logic [3:0] op, input logic sa, input logic sb,
                        input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [RW-1:0] ey, input logic ee);
        bit ok;
        ok = 1'b0;
        bus.in_op    = op;
        bus.in_sa    = sa;
        bus.in_sb    = sb;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_c     = c;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                exp_q.push_back({ee, ey});
                #1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=no_accept required=accept op=%0h", op);
        end
    endtask

    initial begin : monitor
        logic [RW:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                occ = 0;
            end else begin
                check("in_ready", 32'(bus.in_ready), 32'((occ < 2) || bus.out_ready));
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out actual=%0h required=none", bus.out_y);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_y", 32'(bus.out_y), 32'(e[RW-1:0]));
                        check("out_err", 32'(bus.out_err), 32'(e[RW]));
                    end
                end
                occ = occ + int'(bus.in_valid && bus.in_ready) - int'(bus.out_valid && bus.out_ready);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bus.in_valid   = 1'b0;
        bus.in_op      = '0;
        bus.in_sa      = 1'b0;
        bus.in_sb      = 1'b0;
        bus.in_a       = '0;
        bus.in_b       = '0;
        bus.in_c       = '0;
        bus.out_ready  = 1'b1;
        bus.sig_clr    = 1'b0;
        bus_w.in_valid = 1'b0;
        bus_w.in_op    = '0;
        bus_w.in_sa    = 1'b0;
        bus_w.in_sb    = 1'b0;
        bus_w.in_a     = '0;
        bus_w.in_b     = '0;
        bus_w.in_c     = '0;
        bus_w.out_ready = 1'b1;
        bus_w.sig_clr  = 1'b0;

        tick(3);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_y", 32'(bus.out_y), 0);
        check("rst_out_err", 32'(bus.out_err), 0);
        check("rst_sig", 32'(bus.sig), 0);
        check("rst_count", 32'(bus.count), 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 1);

        send(4'd0, 1, 1, 4'b1101, 4'b0010, 4'd0, 5'b11111, 0);
        idle();
        check("lat_s1", 32'(bus.out_valid), 0);
        tick(1);
        check("lat_s2", 32'(bus.out_valid), 1);
        check("lat_y", 32'(bus.out_y), 'h1F);
        tick(2);

        send(4'd0, 1, 0, 4'b1101, 4'b0010, 4'd0, 5'b01111, 0);
        send(4'd4, 1, 1, 4'hF,    4'h1,    4'd0, 5'b00001, 0);
        send(4'd4, 0, 1, 4'hF,    4'h1,    4'd0, 5'b00000, 0);
        send(4'd3, 1, 1, 4'b1000, 4'd1,    4'd0, 5'b11100, 0);
        send(4'd3, 0, 0, 4'b1000, 4'd1,    4'd0, 5'b00100, 0);
        send(4'd2, 0, 0, 4'b0011, 4'd7,    4'd0, 5'b00000, 0);
        send(4'd3, 1, 1, 4'b1000, 4'd7,    4'd0, 5'b11111, 0);
        send(4'd2, 0, 0, 4'b0011, 4'd2,    4'd0, 5'b01100, 0);
        send(4'd2, 1, 1, 4'b1101, 4'd1,    4'd0, 5'b11010, 0);
        send(4'd1, 1, 1, 4'd0,    4'd1,    4'd0, 5'b11111, 0);
        send(4'd1, 0, 0, 4'd2,    4'd5,    4'd0, 5'b11101, 0);
        send(4'd5, 0, 0, 4'd5,    4'd5,    4'd0, 5'b00001, 0);
        send(4'd5, 0, 0, 4'd5,    4'd6,    4'd0, 5'b00000, 0);
        send(4'd5, 1, 0, 4'hF,    4'hF,    4'd0, 5'b00001, 0);
        send(4'd6, 0, 0, 4'd3,    4'd9,    4'd1, 5'b00011, 0);
        send(4'd6, 0, 0, 4'd3,    4'd9,    4'd0, 5'b01001, 0);
        send(4'd6, 1, 1, 4'd3,    4'd9,    4'd0, 5'b11001, 0);
        send(4'd7, 0, 0, 4'b1011, 4'd0,    4'd0, 5'b00001, 0);
        send(4'd7, 1, 1, 4'b1001, 4'd0,    4'd0, 5'b00000, 0);
        send(4'hA, 1, 1, 4'd7,    4'd3,    4'd5, 5'b00000, 1);
        send(4'd0, 0, 0, 4'd1,    4'd1,    4'd0, 5'b00010, 0);
        idle();
        tick(4);

        bus.sig_clr = 1'b1;
        tick(1);
        bus.sig_clr = 1'b0;
        check("clr_sig", 32'(bus.sig), 0);
        check("clr_count", 32'(bus.count), 0);
        send(4'd0, 0, 0, 4'd1, 4'd0, 4'd0, 5'd1, 0);
        idle();
        tick(3);
        check("sig_step1", 32'(bus.sig), 'h01);
        check("count_step1", 32'(bus.count), 1);
        send(4'd0, 0, 0, 4'd1, 4'd1, 4'd0, 5'd2, 0);
        idle();
        tick(3);
        check("sig_step2", 32'(bus.sig), 'h00);
        check("count_step2", 32'(bus.count), 2);
        send(4'd0, 0, 0, 4'd2, 4'd2, 4'd0, 5'd4, 0);
        idle();
        tick(3);
        check("sig_step3", 32'(bus.sig), 'h04);
        check("count_step3", 32'(bus.count), 3);

        bus.out_ready = 1'b0;
        send(4'd0, 0, 0, 4'd2, 4'd1, 4'd0, 5'd3, 0);
        idle();
        tick(1);
        check("hold_valid", 32'(bus.out_valid), 1);
        check("hold_y0", 32'(bus.out_y), 3);
        tick(1);
        check("hold_y1", 32'(bus.out_y), 3);
        check("hold_err", 32'(bus.out_err), 0);
        bus.sig_clr   = 1'b1;
        bus.out_ready = 1'b1;
        tick(1);
        bus.sig_clr = 1'b0;
        check("clr_hs_count", 32'(bus.count), 1);
        check("clr_hs_sig", 32'(bus.sig), 3);
        tick(2);

        bus.sig_clr = 1'b1;
        tick(1);
        bus.sig_clr = 1'b0;
        check("bp_count0", 32'(bus.count), 0);
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    send(4'd0, 0, 0, 4'(i), 4'd1, 4'd0, 5'(i + 1), 0);
                end
                idle();
            end
            begin
                tick(3);
                bus.out_ready = 1'b0;
                tick(6);
                bus.out_ready = 1'b1;
            end
        join
        tick(6);
        check("bp_count10", 32'(bus.count), 10);

        bus.out_ready = 1'b0;
        send(4'd0, 0, 0, 4'd1, 4'd1, 4'd0, 5'd2, 0);
        send(4'd0, 0, 0, 4'd2, 4'd2, 4'd0, 5'd4, 0);
        idle();
        check("full_in_ready", 32'(bus.in_ready), 0);
        check("full_valid", 32'(bus.out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", 32'(bus.out_valid), 0);
        check("arst_sig", 32'(bus.sig), 0);
        check("arst_count", 32'(bus.count), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        send(4'd0, 0, 0, 4'd3, 4'd4, 4'd0, 5'd7, 0);
        idle();
        check("post_rst_s1", 32'(bus.out_valid), 0);
        tick(1);
        check("post_rst_s2", 32'(bus.out_valid), 1);
        check("post_rst_y", 32'(bus.out_y), 7);
        tick(3);

        bus_w.in_op    = 4'd0;
        bus_w.in_a     = 4'd1;
        bus_w.in_b     = 4'd0;
        bus_w.in_valid = 1'b1;
        tick(9);
        bus_w.in_valid = 1'b0;
        tick(4);
        check("wrap_count", 32'(bus_w.count), 1);
        check("wrap_sig", 32'(bus_w.sig), 'h10);

        check("sb_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/expr_pipe_eval.md
# expr_pipe_eval

Parametrised, pipelined mixed-signedness expression evaluator: the registered, handshaked successor to the combinational width/sign expression blocks in the regression suite. It accepts one operation per cycle over a valid/ready interface. Operands are extended to the result width under Verilog sign-context rules, and the block computes one of eight operators. It also keeps a running signature and a result counter, so long random streams can be checked against a golden model at the end of a run.

## Interface
Parameters:
- `W`, default 4: operand width (≥2).
- `RW`, default `W+1`: result width (≥`W`).
- `CW`, default 16: result counter width.

Ports:
- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: operation offered.
- `in_ready`, output, 1: block can accept an operation this cycle.
- `in_op`, input, 4: opcode.
- `in_sa`, input, 1: operand a is signed.
- `in_sb`, input, 1: operand b is signed.
- `in_a`, input, `W`: operand a.
- `in_b`, input, `W`: operand b.
- `in_c`, input, `W`: select operand, used by SEL only.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: downstream accepts the result.
- `out_y`, output, `RW`: result.
- `out_err`, output, 1: reserved opcode was issued.
- `sig_clr`, input, 1: synchronous clear of `sig` and `count`.
- `sig`, output, `RW`: running signature.
- `count`, output, `CW`: number of results consumed.

## Operation
- **Sign context.** The context is signed iff `in_sa & in_sb`; mixed signedness gives an unsigned context. In a signed context `a` and `b` are sign-extended to `RW` bits; otherwise they are zero-extended.
- **Opcodes** (EA and EB are the extended `a` and `b`):
  - 0 ADD: `EA + EB`, truncated to `RW`.
  - 1 SUB: `EA - EB`, truncated to `RW`.
  - 2 SHL: `EA << in_b`. `in_b` is always unsigned; a shift of `RW` or more gives 0.
  - 3 SHR: `EA >> in_b`, arithmetic in a signed context and logical otherwise. A shift of `RW` or more gives all sign bits (signed) or 0 (unsigned).
  - 4 LT: `EA < EB` compared in the context's signedness; the 1-bit result is zero-extended.
  - 5 EQ: `in_a == in_b` on raw bits; the 1-bit result is zero-extended.
  - 6 SEL: `(in_c != 0) ? EA : EB`.
  - 7 RXOR: `^in_a`, zero-extended.
  - 8–15 reserved: `out_y = 0` and `out_err = 1`.
- `out_err` is 0 for opcodes 0–7. It travels with its result.
- **Pipeline.**
  - Stage S1 registers the extended operands, opcode, context and `in_c`.
  - Stage S2 computes and registers `out_y` and `out_err`.
  - Each stage holds a valid bit.
- **Stage advance.**
  - S2 loads when S2 is empty or `out_ready` is high.
  - S1 loads when S1 is empty or S1 advances into S2.
  - `in_ready` = S1 empty or S1 advancing. It is combinational from `out_ready`.
- Results leave strictly in acceptance order. Nothing is dropped or duplicated.
- **Signature.** On each output handshake (`out_valid & out_ready`):
  - `sig <= {sig[RW-2:0], sig[RW-1]} ^ out_y`.
  - `count <= count + 1`, wrapping modulo 2^`CW`.
- **Clear.** `sig_clr` alone loads 0 into `sig` and `count`. `sig_clr` together with a handshake loads `sig <= out_y` and `count <= 1`.

## Timing
- **Reset values:**
  - `out_valid` = 0, `out_y` = 0, `out_err` = 0, `sig` = 0, `count` = 0, both stage valid bits = 0.
  - `in_ready` = 1 one combinational evaluation after reset deasserts.
- Latency: an operation accepted in cycle n shows `out_valid` in cycle n+2 when no backpressure is applied.
- Throughput is one operation per cycle while `out_ready` is held high.
- **Backpressure:**
  - With `out_ready` low, at most two operations are buffered.
  - `in_ready` falls in the cycle that both stages are full.
  - `out_y` and `out_err` hold stable while `out_valid & !out_ready`.
- Operands are sampled only on the `in_valid & in_ready` edge.
- Asserting `rst` mid-stream discards all in-flight operations immediately; there is no partial output.

## Test plan
- **Signed vs unsigned ADD** (`W=4`, `RW=5`):
  - `a=4'b1101`, `b=4'b0010`, `sa=sb=1` → `out_y=5'b11111` at cycle +2.
  - Same operands with `sb=0` → `5'b01111`.
- **LT and SHR sign context:**
  - LT with `a=4'hF`, `b=4'h1`: signed context → `out_y=1`; `sa=0` → 0.
  - SHR with `a=4'b1000`, `b=1`: signed context → `5'b11100`; unsigned → `5'b00100`.
- **Shift saturation:**
  - SHL with `b=4'd7` (≥`RW`) → 0.
  - Signed SHR of `4'b1000` by 7 → `5'b11111`.
- **Backpressure:**
  - Stream 10 ADDs with `in_valid` held high and `out_ready` low for cycles 3–8.
  - `in_ready` must be low exactly while both stages are full.
  - All 10 results appear in order; `count=10`.
- **Reserved opcode and signature:**
  - `op=4'hA` → `out_y=0`, `out_err=1`; the next op 0 gives `out_err=0`.
  - After the sequence ADD=1, ADD=2, `sig=5'b00000 ⟲ ^1 = 00001`, then `00010 ^ 00010 = 0`.
  - `sig_clr` asserted together with a handshake → `count=1`, `sig=out_y`.
- **Reset mid-operation:**
  - Assert `rst` with both stages full → `out_valid=0` asynchronously, `sig=0`, `count=0`.
  - First op after release appears at cycle +2.
- **Counter wrap:**
  - With `CW=3`, consume 9 results → `count=1`.
